// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port, one transaction
// in flight, with fetch starvation relief and a response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [NBITS-1:0] i_addr,
    input  logic             d_req,
    input  logic [NBITS-1:0] d_addr,
    input  logic [NBITS-1:0] d_wdata,
    input  logic             d_we,
    output logic             i_gnt,
    output logic             d_gnt,
    output logic             i_valid,
    output logic             d_valid,
    output logic [NBITS-1:0] rdata,
    output logic             err,
    output logic             mem_req,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    output logic             mem_we,
    input  logic             mem_rdy,
    input  logic             mem_valid,
    input  logic [NBITS-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] wait_cnt;
    logic          starved;

    // Grants are combinational so the requester sees them in the arbitration cycle.
    always_comb begin
        starved = i_req && (starve_cnt == SW'(STARVE_MAX));
        d_gnt   = (state == IDLE) && d_req && !starved;
        i_gnt   = (state == IDLE) && i_req && !d_gnt;
        mem_req = (state == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_gnt || d_gnt) begin
                        owner     <= d_gnt ? OWN_D : OWN_I;
                        mem_addr  <= d_gnt ? d_addr : i_addr;
                        mem_wdata <= d_gnt ? d_wdata : '0;
                        mem_we    <= d_gnt && d_we;
                        state     <= REQ;
                        if (i_gnt)
                            starve_cnt <= '0;
                        else if (i_req && starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                REQ: begin
                    if (mem_rdy) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_valid) begin
                        rdata   <= mem_rdata;
                        i_valid <= (owner == OWN_I);
                        d_valid <= (owner == OWN_D);
                        state   <= IDLE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        // Memory never answered: abandon the transaction.
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
